// File: rtl/demux4_route.sv
// demux4_route: routes one input word per cycle to one of four single-entry output slots.
// Define DEMUX4_ROUTE_XFER_CNT_EN to add 16-bit per-channel output transfer counters.
//
// Slot state (one per channel)
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_EMPTY | slot holds no word; out_valid[k]=0, out_data(k)=DISABLED
//   S_FULL  | slot holds a word; out_valid[k]=1, data held until consumed
module demux4_route #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] DISABLED = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3
`ifdef DEMUX4_ROUTE_XFER_CNT_EN
    ,
    output logic [15:0]      xfer_cnt0,
    output logic [15:0]      xfer_cnt1,
    output logic [15:0]      xfer_cnt2,
    output logic [15:0]      xfer_cnt3
`endif
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    slot_state_t      state_q [4];
    slot_state_t      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];
    logic [3:0]       full;
    logic [3:0]       load;
    logic [3:0]       drain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= S_EMPTY;
                data_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

    always_comb begin
        full     = '0;
        load     = '0;
        drain    = '0;
        in_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            full[k]    = (state_q[k] == S_FULL);
        end
        // A full slot still accepts when its consumer empties it in the same cycle.
        in_ready = rst_n & en & (~full[in_sel] | out_ready[in_sel]);
        for (int k = 0; k < 4; k++) begin
            load[k]  = in_valid & in_ready & (in_sel == k[1:0]);
            drain[k] = full[k] & out_ready[k];
            if (load[k]) begin
                state_d[k] = S_FULL;
                data_d[k]  = in_data;
            end else if (drain[k]) begin
                state_d[k] = S_EMPTY;
            end
        end
    end

    assign out_valid = full;
    assign out_data0 = full[0] ? data_q[0] : DISABLED;
    assign out_data1 = full[1] ? data_q[1] : DISABLED;
    assign out_data2 = full[2] ? data_q[2] : DISABLED;
    assign out_data3 = full[3] ? data_q[3] : DISABLED;

`ifdef DEMUX4_ROUTE_XFER_CNT_EN
    logic [15:0] cnt_q [4];

    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (drain[k]) cnt_q[k] <= cnt_q[k] + 16'd1;
            end
        end
    end

    assign xfer_cnt0 = cnt_q[0];
    assign xfer_cnt1 = cnt_q[1];
    assign xfer_cnt2 = cnt_q[2];
    assign xfer_cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux4_route.sv
// Bench for demux4_route: directed scenarios plus a per-channel queue scoreboard on every cycle.
// Build with DEMUX4_ROUTE_XFER_CNT_EN defined to include the transfer counter scenario.
module tb_demux4_route;

    localparam logic [31:0] DIS_D = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_sel = 2'd0;
    logic [31:0] in_data = '0;
    logic [3:0]  out_ready = '0;

    logic        in_ready, in_ready_d;
    logic [3:0]  out_valid, out_valid_d;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic [31:0] dd0, dd1, dd2, dd3;
`ifdef DEMUX4_ROUTE_XFER_CNT_EN
    logic [15:0] cnt0, cnt1, cnt2, cnt3;
    logic [15:0] dcnt0, dcnt1, dcnt2, dcnt3;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    demux4_route #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3)
`ifdef DEMUX4_ROUTE_XFER_CNT_EN
        , .xfer_cnt0(cnt0), .xfer_cnt1(cnt1), .xfer_cnt2(cnt2), .xfer_cnt3(cnt3)
`endif
    );

    demux4_route #(.WIDTH(32), .DISABLED(DIS_D)) dut_d (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready_d),
        .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid_d), .out_ready(out_ready),
        .out_data0(dd0), .out_data1(dd1), .out_data2(dd2), .out_data3(dd3)
`ifdef DEMUX4_ROUTE_XFER_CNT_EN
        , .xfer_cnt0(dcnt0), .xfer_cnt1(dcnt1), .xfer_cnt2(dcnt2), .xfer_cnt3(dcnt3)
`endif
    );

    // Scoreboard: expected words per channel, pushed on accepted input, popped on output transfer.
    logic [31:0] sb [4][$];
    logic [31:0] mon_od [4];
    logic [31:0] mon_exp_d;
    logic        mon_exp_v [4];
    logic        mon_exp_rdy;

    always @(negedge rst_n) begin
        for (int k = 0; k < 4; k++) sb[k].delete();
    end

    always @(negedge clk) begin
        mon_od[0] = out_data0;
        mon_od[1] = out_data1;
        mon_od[2] = out_data2;
        mon_od[3] = out_data3;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) sb[k].delete();
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 4'b0000) begin
                fails++;
                $display("FAIL sb_in_reset: in_ready=%b out_valid=%b, expected 0 and 0000", in_ready, out_valid);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                mon_exp_v[k] = (sb[k].size() != 0);
                mon_exp_d    = mon_exp_v[k] ? sb[k][0] : 32'h0;
                tests++;
                if (out_valid[k] !== mon_exp_v[k] || mon_od[k] !== mon_exp_d) begin
                    fails++;
                    $display("FAIL sb_ch%0d: valid=%b data=%h, expected valid=%b data=%h",
                             k, out_valid[k], mon_od[k], mon_exp_v[k], mon_exp_d);
                end
            end
            mon_exp_rdy = en && (!mon_exp_v[in_sel] || out_ready[in_sel]);
            tests++;
            if (in_ready !== mon_exp_rdy) begin
                fails++;
                $display("FAIL sb_in_ready: got %b expected %b (sel=%0d)", in_ready, mon_exp_rdy, in_sel);
            end
            for (int k = 0; k < 4; k++) begin
                if (mon_exp_v[k] && out_ready[k]) void'(sb[k].pop_front());
            end
            if (in_valid && mon_exp_rdy) sb[in_sel].push_back(in_data);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all;
        in_valid  = 1'b0;
        out_ready = 4'hF;
        tick;
        tick;
    endtask

    task automatic test_reset;
        en = 1'b1;
        in_valid = 1'b1;
        #1;
        tests++;
        if (out_valid !== 4'b0000 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b, expected 0000 and 0", out_valid, in_ready);
        end
        tests++;
        if ({out_data0, out_data1, out_data2, out_data3} !== 128'h0) begin
            fails++;
            $display("FAIL reset_data: %h %h %h %h, expected all 0", out_data0, out_data1, out_data2, out_data3);
        end
        tests++;
        if ({dd0, dd1, dd2, dd3} !== {4{DIS_D}}) begin
            fails++;
            $display("FAIL reset_data_disabled: %h %h %h %h, expected all %h", dd0, dd1, dd2, dd3, DIS_D);
        end
        tick;
        in_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        tests++;
        if (out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL reset_release: out_valid=%b expected 0000", out_valid);
        end
    endtask

    task automatic test_route;
        en = 1'b1;
        out_ready = 4'hF;
        in_valid = 1'b1;
        in_sel = 2'd2;
        in_data = 32'hA5A5_0002;
        tick;
        in_valid = 1'b0;
        in_sel = 2'bxx;
        in_data = 'x;
        tests++;
        if (out_valid !== 4'b0100 || out_data2 !== 32'hA5A5_0002) begin
            fails++;
            $display("FAIL route: out_valid=%b data2=%h, expected 0100 a5a50002", out_valid, out_data2);
        end
        tests++;
        if ({out_data0, out_data1, out_data3} !== 96'h0) begin
            fails++;
            $display("FAIL route_idle: %h %h %h, expected all 0", out_data0, out_data1, out_data3);
        end
        tick;
        tests++;
        if (out_valid !== 4'b0000 || out_data2 !== 32'h0) begin
            fails++;
            $display("FAIL route_drain: out_valid=%b data2=%h, expected 0000 0", out_valid, out_data2);
        end
        in_sel = 2'd0;
        in_data = '0;
    endtask

    task automatic test_backpressure;
        out_ready = 4'b1101;
        in_valid = 1'b1;
        in_sel = 2'd1;
        in_data = 32'h11;
        tick;
        in_data = 32'h22;
        #1;
        tests++;
        if (in_ready !== 1'b0 || out_data1 !== 32'h11) begin
            fails++;
            $display("FAIL bp_block: in_ready=%b data1=%h, expected 0 00000011", in_ready, out_data1);
        end
        tick;
        tests++;
        if (out_valid[1] !== 1'b1 || out_data1 !== 32'h11) begin
            fails++;
            $display("FAIL bp_hold: valid1=%b data1=%h, expected 1 00000011", out_valid[1], out_data1);
        end
        in_sel = 2'd3;
        in_data = 32'h33;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_other_ready: in_ready=%b expected 1", in_ready);
        end
        tick;
        tests++;
        if (out_valid !== 4'b1010 || out_data3 !== 32'h33 || out_data1 !== 32'h11) begin
            fails++;
            $display("FAIL bp_other: out_valid=%b data3=%h data1=%h, expected 1010 33 11",
                     out_valid, out_data3, out_data1);
        end
        drain_all;
    endtask

    task automatic test_simultaneous;
        out_ready = 4'b1110;
        in_valid = 1'b1;
        in_sel = 2'd0;
        in_data = 32'h1;
        tick;
        out_ready = 4'b1111;
        in_data = 32'h2;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL simul_ready: in_ready=%b expected 1", in_ready);
        end
        tick;
        in_valid = 1'b0;
        tests++;
        if (out_valid[0] !== 1'b1 || out_data0 !== 32'h2) begin
            fails++;
            $display("FAIL simul: valid0=%b data0=%h, expected 1 00000002", out_valid[0], out_data0);
        end
        drain_all;
    endtask

    task automatic test_disable;
        en = 1'b1;
        out_ready = 4'b0111;
        in_valid = 1'b1;
        in_sel = 2'd3;
        in_data = 32'h33;
        tick;
        en = 1'b0;
        in_sel = 2'd0;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL disable_ready: in_ready=%b expected 0", in_ready);
        end
        tick;
        tests++;
        if (out_valid !== 4'b1000 || out_data3 !== 32'h33) begin
            fails++;
            $display("FAIL disable_hold: out_valid=%b data3=%h, expected 1000 00000033", out_valid, out_data3);
        end
        out_ready = 4'b1111;
        tick;
        tests++;
        if (out_valid !== 4'b0000 || out_data3 !== 32'h0 || dd3 !== DIS_D) begin
            fails++;
            $display("FAIL disable_drain: out_valid=%b data3=%h dd3=%h, expected 0000 0 %h",
                     out_valid, out_data3, dd3, DIS_D);
        end
        in_valid = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_reset_mid;
        en = 1'b1;
        out_ready = 4'b0000;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_sel = k[1:0];
            in_data = 32'hC0DE_0000 + k;
            tick;
        end
        in_valid = 1'b0;
        tests++;
        if (out_valid_d !== 4'b1111 || dd2 !== 32'hC0DE_0002) begin
            fails++;
            $display("FAIL rmid_full: out_valid=%b dd2=%h, expected 1111 c0de0002", out_valid_d, dd2);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid_d !== 4'b0000 || out_valid !== 4'b0000 || in_ready_d !== 1'b0) begin
            fails++;
            $display("FAIL rmid_clear: out_valid=%b/%b in_ready=%b, expected 0000 0",
                     out_valid_d, out_valid, in_ready_d);
        end
        tests++;
        if ({dd0, dd1, dd2, dd3} !== {4{DIS_D}}) begin
            fails++;
            $display("FAIL rmid_data: %h %h %h %h, expected all %h", dd0, dd1, dd2, dd3, DIS_D);
        end
        #1;
        rst_n = 1'b1;
        out_ready = 4'hF;
        tick;
        tests++;
        if (out_valid_d !== 4'b0000 || dd0 !== DIS_D) begin
            fails++;
            $display("FAIL rmid_after: out_valid=%b dd0=%h, expected 0000 %h", out_valid_d, dd0, DIS_D);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel = 2'($urandom_range(0, 3));
            in_data = $urandom;
            out_ready = 4'($urandom_range(0, 15));
            tick;
        end
        en = 1'b1;
        drain_all;
        tests++;
        if (out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL b2b_drained: out_valid=%b expected 0000", out_valid);
        end
    endtask

`ifdef DEMUX4_ROUTE_XFER_CNT_EN
    task automatic test_xfer_cnt;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({cnt0, cnt1, cnt2, cnt3} !== 64'h0) begin
            fails++;
            $display("FAIL cnt_reset: %h %h %h %h, expected all 0", cnt0, cnt1, cnt2, cnt3);
        end
        tick;
        rst_n = 1'b1;
        en = 1'b1;
        out_ready = 4'hF;
        in_sel = 2'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            in_data = i;
            tick;
        end
        in_valid = 1'b0;
        tick;
        tests++;
        if (cnt0 !== 16'd1 || {cnt1, cnt2, cnt3} !== 48'h0) begin
            fails++;
            $display("FAIL cnt_wrap: cnt0=%0d cnt1=%0d cnt2=%0d cnt3=%0d, expected 1 0 0 0",
                     cnt0, cnt1, cnt2, cnt3);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_route;
        test_backpressure;
        test_simultaneous;
        test_disable;
        test_reset_mid;
        test_back_to_back;
`ifdef DEMUX4_ROUTE_XFER_CNT_EN
        test_xfer_cnt;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux4_route.md
DEMUX4_ROUTE -- requirements
Module: demux4_route

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width in bits.
REQ-002 The block SHALL have parameter DISABLED, default 0: value driven on an idle output's data, cast to WIDTH bits.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: routing enable.
REQ-006 The block SHALL have port in_valid, input, 1 bit: input word present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: input word accepted this cycle.
REQ-008 The block SHALL have port in_sel, input, 2 bits: destination channel 0-3.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: input word.
REQ-010 The block SHALL have port out_valid, output, 4 bits: bit k means channel k holds a word.
REQ-011 The block SHALL have port out_ready, input, 4 bits: bit k means the channel k consumer takes the word.
REQ-012 The block SHALL have ports out_data0 to out_data3, each output, WIDTH bits: channel data.

Function
REQ-013 Each channel k SHALL contain a one-entry slot with states EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-014 in_ready SHALL be combinational and equal en AND (NOT out_valid[in_sel] OR out_ready[in_sel]).
REQ-015 An input transfer SHALL occur when in_valid AND in_ready; in_data is then captured into slot in_sel at that clock edge.
REQ-016 Latency SHALL be one cycle: the word appears on out_data(in_sel), with out_valid set, in the cycle after the transfer.
REQ-017 An output transfer on channel k SHALL occur when out_valid[k] AND out_ready[k]; slot k then goes EMPTY unless it is reloaded in the same cycle.
REQ-018 When an input transfer into channel k and an output transfer on channel k occur in the same cycle, slot k SHALL stay FULL with the new word, with no bubble and no loss.
REQ-019 While out_valid[k]=1 and out_ready[k]=0, out_data(k) SHALL hold stable.
REQ-020 While out_valid[k]=0, out_data(k) SHALL equal DISABLED, never stale data.
REQ-021 Channels SHALL be independent: a stalled channel does not block input destined for another channel.
REQ-022 When en=0, in_ready SHALL be 0; FULL slots SHALL still drain normally.
REQ-023 in_sel and in_data SHALL be ignored when in_valid=0, including X values.
REQ-024 At most one slot SHALL be loaded per cycle.

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously clear all slots to EMPTY: out_valid=4'b0000 and every out_data equal to DISABLED.
REQ-026 While rst_n=0, in_ready SHALL be 0.
REQ-027 Assertion of rst_n mid-operation SHALL discard held words with no output transfer.
REQ-028 Deassertion of rst_n SHALL take effect at the next clk edge.

Configuration
REQ-029 With macro DEMUX4_ROUTE_XFER_CNT_EN defined, the block SHALL add outputs xfer_cnt0 to xfer_cnt3, each 16 bits, counting output transfers per channel.
REQ-030 The xfer_cnt counters SHALL reset to 0, increment by 1 per output transfer, and wrap from 16'hFFFF to 16'h0000.
REQ-031 Without DEMUX4_ROUTE_XFER_CNT_EN, those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Route: with en=1 and all out_ready=1, drive in_sel=2 and in_data=32'hA5A5_0002 -> out_valid=4'b0100 and out_data2=32'hA5A5_0002 next cycle; the other data outputs equal 0.
REQ-033 Backpressure: load channel 1 with 32'h11, hold out_ready[1]=0, then present a second word for channel 1 -> in_ready=0 and out_data1 stays 32'h11; a word for channel 3 is accepted meanwhile.
REQ-034 Simultaneous: channel 0 FULL with 32'h1; in the same cycle out_ready[0]=1 and input 32'h2 targets channel 0 -> next cycle out_valid[0]=1 and out_data0=32'h2.
REQ-035 Disable: load channel 3 with 32'h33, set en=0 and in_valid=1 -> in_ready=0; the channel 3 word drains when out_ready[3]=1, then out_data3=DISABLED.
REQ-036 Reset mid-operation: with all slots FULL, pulse rst_n low between clock edges -> out_valid=0 immediately and all data outputs equal DISABLED; run with DISABLED=32'hDEAD_BEEF.
REQ-037 Counter, macro defined: perform 65537 output transfers on channel 0 -> xfer_cnt0=1 and xfer_cnt1 to xfer_cnt3=0.
